// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the KGP-RISC execute stage: opcodes, widths and
// the registered result+flags bundle.
package kgp_alu_pkg;

  localparam int DATA_W = 32;
  localparam int DIFF_W = 6;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_COMP  = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SHLL  = 4'd4;
  localparam logic [3:0] OP_SHRL  = 4'd5;
  localparam logic [3:0] OP_SHLLV = 4'd6;
  localparam logic [3:0] OP_SHRLV = 4'd7;
  localparam logic [3:0] OP_SHRA  = 4'd8;
  localparam logic [3:0] OP_SHRAV = 4'd9;
  localparam logic [3:0] OP_DIFF  = 4'd10;

  // Result word plus the branch flags that travel with it to writeback.
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              zero;
    logic              sign;
  } alu_res_t;

  localparam int RES_BUNDLE_W = $bits(alu_res_t);

  // Variable shifts take their amount from rt instead of the immediate.
  function automatic logic is_var_shift(input logic [3:0] op);
    return (op == OP_SHLLV) || (op == OP_SHRLV) || (op == OP_SHRAV);
  endfunction

  function automatic logic is_right_shift(input logic [3:0] op);
    return (op == OP_SHRL) || (op == OP_SHRLV) || (op == OP_SHRA) || (op == OP_SHRAV);
  endfunction

  function automatic logic is_arith_shift(input logic [3:0] op);
    return (op == OP_SHRA) || (op == OP_SHRAV);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between decode, the execute stage and writeback.
interface alu_exec_stage_if
  import kgp_alu_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int DCW = DIFF_W
);
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic [W-1:0]   in_rs;
  logic [W-1:0]   in_rt;
  logic [4:0]     in_shamt;
  logic [DCW-1:0] diff_cnt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_res;
  logic           out_carry;
  logic           out_zero;
  logic           out_sign;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_shamt, diff_cnt, out_ready,
    input  in_ready, out_valid, out_res, out_carry, out_zero, out_sign
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_shamt, diff_cnt, out_ready,
    output in_ready, out_valid, out_res, out_carry, out_zero, out_sign
  );
endinterface

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter: left logical, right logical or
// right arithmetic (sign replicated) by 0..31 positions.
module alu_shifter #(
  parameter int W = 32
) (
  input  logic [W-1:0] data,
  input  logic [4:0]   amt,
  input  logic         dir,    // 1 = right, 0 = left
  input  logic         arith,  // right shifts only: replicate data[W-1]
  output logic [W-1:0] result
);

  logic [W-1:0] acc;

  // One stage per amount bit, shifting by 1, 2, 4, 8, 16.
  always_comb begin
    acc = data;
    for (int i = 0; i < 5; i++) begin
      if (amt[i]) begin
        if (!dir)
          acc = acc << (2 ** i);
        else if (arith)
          acc = W'($signed(acc) >>> (2 ** i));
        else
          acc = acc >> (2 ** i);
      end
    end
    result = acc;
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: op mux + flags feeding a 2-entry skid buffer
// (main register drives the outputs, skid register catches one op under
// backpressure so in_ready can come straight from a flop).
module alu_exec_stage
  import kgp_alu_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int DCW = DIFF_W
) (
  input logic             clk,
  input logic             rst,
  alu_exec_stage_if.slave bus
);

  typedef struct packed {
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         sign;
  } bundle_t;

  bundle_t      main_reg, skid_reg, result_next;
  logic         main_valid_reg, skid_valid_reg;
  logic         accept;
  logic [W:0]   sum;
  logic [W-1:0] res_raw, sh_res;
  logic         carry_raw;
  logic [4:0]   sh_amt;
  logic         sh_dir, sh_arith;

  alu_shifter #(.W(W)) u_shifter (
    .data   (bus.in_rs),
    .amt    (sh_amt),
    .dir    (sh_dir),
    .arith  (sh_arith),
    .result (sh_res)
  );

  // Shifter controls decoded from the opcode.
  always_comb begin
    sh_amt   = is_var_shift(bus.in_op) ? bus.in_rt[4:0] : bus.in_shamt;
    sh_dir   = is_right_shift(bus.in_op);
    sh_arith = is_arith_shift(bus.in_op);
  end

  // Op mux and flags; undefined opcodes give 0 with carry clear.
  always_comb begin
    sum       = '0;
    res_raw   = '0;
    carry_raw = 1'b0;
    case (bus.in_op)
      OP_ADD: begin
        sum       = {1'b0, bus.in_rs} + {1'b0, bus.in_rt};
        res_raw   = sum[W-1:0];
        carry_raw = sum[W];
      end
      OP_COMP: begin
        // Two's complement negate; carry out only when rt == 0.
        sum       = {1'b0, ~bus.in_rt} + {{W{1'b0}}, 1'b1};
        res_raw   = sum[W-1:0];
        carry_raw = sum[W];
      end
      OP_AND:  res_raw = bus.in_rs & bus.in_rt;
      OP_XOR:  res_raw = bus.in_rs ^ bus.in_rt;
      OP_SHLL, OP_SHRL, OP_SHLLV, OP_SHRLV, OP_SHRA, OP_SHRAV:
               res_raw = sh_res;
      OP_DIFF: res_raw = {{(W-DCW){1'b0}}, bus.diff_cnt};
      default: res_raw = '0;
    endcase
    result_next.res   = res_raw;
    result_next.carry = carry_raw;
    result_next.zero  = (res_raw == '0);
    result_next.sign  = res_raw[W-1];
  end

  // Skid full is the only condition that blocks upstream.
  assign accept = bus.in_valid && !skid_valid_reg;

  // Skid buffer control: fill main first, spill into skid when stalled,
  // refill main from skid on drain. Reset flushes both entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else if (main_valid_reg && bus.out_ready) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_reg <= result_next;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (!main_valid_reg) begin
      if (accept) begin
        main_reg       <= result_next;
        main_valid_reg <= 1'b1;
      end
    end else if (accept) begin
      skid_reg       <= result_next;
      skid_valid_reg <= 1'b1;
    end
  end

  assign bus.in_ready  = !skid_valid_reg;
  assign bus.out_valid = main_valid_reg;
  assign bus.out_res   = main_reg.res;
  assign bus.out_carry = main_reg.carry;
  assign bus.out_zero  = main_reg.zero;
  assign bus.out_sign  = main_reg.sign;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: op vectors, backpressure, streaming
// throughput and asynchronous reset flush.
module tb_alu_exec_stage;
  import kgp_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_exec_stage_if #(.W(32), .DCW(6)) bus ();

  alu_exec_stage #(.W(32), .DCW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [5:0] dc);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_shamt = sh;
    bus.diff_cnt = dc;
  endtask

  // Called at a negedge with the stage empty and out_ready=1.
  task automatic exec_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] sh, input logic [5:0] dc,
                         input logic [31:0] exp_res, input logic exp_c);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    drive(op, rs, rt, sh, dc);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_res"},   64'(bus.out_res), 64'(exp_res));
    chk({tag, "_carry"}, 64'(bus.out_carry), 64'(exp_c));
    chk({tag, "_zero"},  64'(bus.out_zero), 64'(exp_res == 32'd0));
    chk({tag, "_sign"},  64'(bus.out_sign), 64'(exp_res[31]));
    $display("txn %s op=%0d rs=%08h rt=%08h -> res=%08h c=%0b", tag, op, rs, rt,
             bus.out_res, bus.out_carry);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_shamt  = '0;
    bus.diff_cnt  = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_res",   64'(bus.out_res), 64'd0);
    chk("rst_carry", 64'(bus.out_carry), 64'd0);
    chk("rst_zero",  64'(bus.out_zero), 64'd0);
    chk("rst_sign",  64'(bus.out_sign), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

    // Directed op vectors, out_ready held high.
    bus.out_ready = 1'b1;
    exec_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 6'd0, 32'h0, 1'b1);
    @(negedge clk);
    chk("add_one_cycle", 64'(bus.out_valid), 64'd0);
    exec_op("diff_b3",   OP_DIFF,  32'h8, 32'h0, 5'd0, 6'd4, 32'd4, 1'b0);
    exec_op("diff_eq",   OP_DIFF,  32'h1234, 32'h1234, 5'd0, 6'd33, 32'd33, 1'b0);
    exec_op("shrav_31",  OP_SHRAV, 32'h8000_0000, 32'h1F, 5'd0, 6'd0, 32'hFFFF_FFFF, 1'b0);
    exec_op("shrl_31",   OP_SHRL,  32'h8000_0000, 32'h0, 5'd31, 6'd0, 32'h1, 1'b0);
    exec_op("comp_min",  OP_COMP,  32'h0, 32'h8000_0000, 5'd0, 6'd0, 32'h8000_0000, 1'b0);
    exec_op("comp_zero", OP_COMP,  32'h0, 32'h0, 5'd0, 6'd0, 32'h0, 1'b1);
    exec_op("comp_five", OP_COMP,  32'h0, 32'h5, 5'd0, 6'd0, 32'hFFFF_FFFB, 1'b0);
    exec_op("and",       OP_AND,   32'h0000_F0F0, 32'h0000_FF00, 5'd0, 6'd0, 32'h0000_F000, 1'b0);
    exec_op("xor",       OP_XOR,   32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 6'd0, 32'h5A5A_A5A5, 1'b0);
    exec_op("shll_31",   OP_SHLL,  32'h1, 32'h0, 5'd31, 6'd0, 32'h8000_0000, 1'b0);
    exec_op("shll_0",    OP_SHLL,  32'h1234_5678, 32'h0, 5'd0, 6'd0, 32'h1234_5678, 1'b0);
    exec_op("shllv_4",   OP_SHLLV, 32'h3, 32'hFFFF_FFE4, 5'd9, 6'd0, 32'h30, 1'b0);
    exec_op("shrlv_31",  OP_SHRLV, 32'h8000_0000, 32'h1F, 5'd0, 6'd0, 32'h1, 1'b0);
    exec_op("shra_4",    OP_SHRA,  32'h8000_0000, 32'h0, 5'd4, 6'd0, 32'hF800_0000, 1'b0);
    exec_op("shra_pos",  OP_SHRA,  32'h4000_0000, 32'h0, 5'd2, 6'd0, 32'h1000_0000, 1'b0);
    exec_op("add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'h1, 5'd0, 6'd0, 32'h8000_0000, 1'b0);
    exec_op("undef",     4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 6'd7, 32'h0, 1'b0);
    @(negedge clk);
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Backpressure: three ops, only two fit.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'd1, 32'd2, 5'd0, 6'd0);           // A -> 3
    @(negedge clk);
    chk("bp_ready_a", 64'(bus.in_ready), 64'd1);
    drive(OP_ADD, 32'd10, 32'd20, 5'd0, 6'd0);         // B -> 30
    @(negedge clk);
    chk("bp_ready_full", 64'(bus.in_ready), 64'd0);
    drive(OP_XOR, 32'hF, 32'h1, 5'd0, 6'd0);           // C -> 0xE, held off
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_stall_res",   64'(bus.out_res), 64'd3);
    end
    $display("txn bp_a res=%08h", bus.out_res);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_b_res",   64'(bus.out_res), 64'd30);
    chk("bp_b_ready", 64'(bus.in_ready), 64'd1);
    $display("txn bp_b res=%08h", bus.out_res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_c_res",   64'(bus.out_res), 64'hE);
    $display("txn bp_c res=%08h", bus.out_res);
    @(negedge clk);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Throughput: one op per cycle, results stream in order.
    for (int i = 0; i < 100; i++) begin
      chk("tp_ready", 64'(bus.in_ready), 64'd1);
      drive(OP_ADD, 32'(i), 32'(3 * i), 5'd0, 6'd0);
      @(negedge clk);
      chk("tp_valid", 64'(bus.out_valid), 64'd1);
      chk("tp_res",   64'(bus.out_res), 64'(4 * i));
    end
    bus.in_valid = 1'b0;
    $display("txn tp_last res=%08h", bus.out_res);
    @(negedge clk);
    chk("tp_empty", 64'(bus.out_valid), 64'd0);

    // Async reset with both entries full.
    bus.out_ready = 1'b0;
    drive(OP_ADD, 32'd5, 32'd5, 5'd0, 6'd0);
    @(negedge clk);
    drive(OP_ADD, 32'd6, 32'd6, 5'd0, 6'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("full_valid", 64'(bus.out_valid), 64'd1);
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    chk("full_res",   64'(bus.out_res), 64'd10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    $display("txn arst valid=%0b", bus.out_valid);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("arst_after_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_after_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_after_res",   64'(bus.out_res), 64'd0);
    @(negedge clk);
    chk("arst_no_stale", 64'(bus.out_valid), 64'd0);
    exec_op("arst_new", OP_ADD, 32'd7, 32'd8, 5'd0, 6'd0, 32'd15, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
